// File: rtl/note_sequencer.sv
// note_sequencer
//
// Plays a 16-entry note table. Each entry holds a 12-bit frequency code
// (0 = rest) and a 4-bit duration in sequencer ticks (0 = end of sequence).
// A note lasts dur ticks with the gate open. It is followed by GAP_TICKS
// silent ticks, and then the next entry starts. One tick is TICK_DIV clk
// cycles long.
//
// Parameters
//   TICK_DIV   clk cycles per sequencer tick (>= 2)
//   GAP_TICKS  silent ticks after every note (>= 1)
//
// Ports
//   clk        system clock
//   rst_n      synchronous active-low reset (the note table is not cleared)
//   start      one-cycle pulse: begin playback at entry 0 (accepted in IDLE only)
//   stop       one-cycle pulse: abort playback (wins over start)
//   load_we    note-table write strobe, ignored while busy or in reset
//   load_addr  note-table write index
//   load_freq  frequency code to write
//   load_dur   duration to write
//   freq       frequency code to the oscillators
//   play       gate to the signal adder
//   busy       high in NOTE or GAP
//   step_idx   index of the entry being played
//   done       one-cycle pulse when playback completes
//
// Build option
//   SEQ_LOOP_EN  when defined, reaching the end of the sequence restarts at
//                entry 0 instead of returning to IDLE. Only stop or reset
//                ends playback.

module note_sequencer #(
    parameter int TICK_DIV  = 12500000,
    parameter int GAP_TICKS = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stop,
    input  logic        load_we,
    input  logic [3:0]  load_addr,
    input  logic [11:0] load_freq,
    input  logic [3:0]  load_dur,
    output logic [11:0] freq,
    output logic        play,
    output logic        busy,
    output logic [3:0]  step_idx,
    output logic        done
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int GW = $clog2(GAP_TICKS + 1);
    localparam int TW = (GW > 4) ? GW : 4;
    localparam logic [PW-1:0] PMAX     = PW'(TICK_DIV - 1);
    localparam logic [TW-1:0] GAP_LAST = TW'(GAP_TICKS - 1);

    typedef enum logic [1:0] {S_IDLE, S_NOTE, S_GAP} state_t;

    logic [11:0] tbl_freq [16];
    logic [3:0]  tbl_dur  [16];

    state_t        state, state_nxt;
    logic [PW-1:0] presc, presc_nxt;
    logic [TW-1:0] tcnt, tcnt_nxt;
    logic [3:0]    cur_dur, cur_dur_nxt;
    logic [11:0]   freq_nxt;
    logic          play_nxt;
    logic          done_nxt;
    logic [3:0]    idx_nxt;

    logic          tick;
    logic [3:0]    idx_inc;
    logic          seq_end;
    logic [TW-1:0] note_last;
    logic          load_note;
    logic [3:0]    load_sel;
    logic          go_idle;

    assign tick      = (presc == PMAX);
    assign idx_inc   = step_idx + 4'd1;
    // The end is reached after entry 15, or when the next entry is a marker.
    assign seq_end   = (step_idx == 4'd15) || (tbl_dur[idx_inc] == 4'd0);
    // The duration is latched at note entry and is never 0 while in NOTE.
    assign note_last = TW'(cur_dur - 4'd1);

    // The table has no reset. Writes are accepted only while idle and out of reset.
    always_ff @(posedge clk) begin
        if (rst_n && load_we && !busy) begin
            tbl_freq[load_addr] <= load_freq;
            tbl_dur[load_addr]  <= load_dur;
        end
    end

    always_comb begin
        state_nxt   = state;
        presc_nxt   = tick ? '0 : presc + PW'(1);
        tcnt_nxt    = tcnt;
        cur_dur_nxt = cur_dur;
        freq_nxt    = freq;
        play_nxt    = play;
        idx_nxt     = step_idx;
        done_nxt    = 1'b0;
        load_note   = 1'b0;
        load_sel    = 4'd0;
        go_idle     = 1'b0;

        case (state)
            S_IDLE: begin
                presc_nxt = '0;
                if (start && !stop) begin
                    if (tbl_dur[0] != 4'd0) begin
                        load_note = 1'b1;
                        load_sel  = 4'd0;
                    end else begin
                        done_nxt = 1'b1;
                    end
                end
            end
            S_NOTE: begin
                if (stop) begin
                    go_idle = 1'b1;
                end else if (tick) begin
                    if (tcnt == note_last) begin
                        // Close the gate. freq keeps its value through the gap.
                        state_nxt = S_GAP;
                        play_nxt  = 1'b0;
                        tcnt_nxt  = '0;
                        presc_nxt = '0;
                    end else begin
                        tcnt_nxt = tcnt + TW'(1);
                    end
                end
            end
            S_GAP: begin
                if (stop) begin
                    go_idle = 1'b1;
                end else if (tick) begin
                    if (tcnt == GAP_LAST) begin
                        if (seq_end) begin
`ifdef SEQ_LOOP_EN
                            load_note = 1'b1;
                            load_sel  = 4'd0;
`else
                            go_idle  = 1'b1;
                            done_nxt = 1'b1;
`endif
                        end else begin
                            load_note = 1'b1;
                            load_sel  = idx_inc;
                        end
                    end else begin
                        tcnt_nxt = tcnt + TW'(1);
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        if (go_idle) begin
            state_nxt = S_IDLE;
            freq_nxt  = '0;
            play_nxt  = 1'b0;
            idx_nxt   = 4'd0;
            tcnt_nxt  = '0;
            presc_nxt = '0;
        end

        // Sample the entry now. Later table contents cannot affect this note.
        if (load_note) begin
            state_nxt   = S_NOTE;
            idx_nxt     = load_sel;
            freq_nxt    = tbl_freq[load_sel];
            play_nxt    = (tbl_freq[load_sel] != 12'd0);
            cur_dur_nxt = tbl_dur[load_sel];
            tcnt_nxt    = '0;
            presc_nxt   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            presc    <= '0;
            tcnt     <= '0;
            cur_dur  <= '0;
            freq     <= '0;
            play     <= 1'b0;
            busy     <= 1'b0;
            step_idx <= '0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            presc    <= presc_nxt;
            tcnt     <= tcnt_nxt;
            cur_dur  <= cur_dur_nxt;
            freq     <= freq_nxt;
            play     <= play_nxt;
            busy     <= (state_nxt != S_IDLE);
            step_idx <= idx_nxt;
            done     <= done_nxt;
        end
    end

endmodule

// File: tb/tb_note_sequencer.sv
module tb_note_sequencer;

    localparam int TD = 4;
    localparam int GT = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        load_we = 1'b0;
    logic [3:0]  load_addr = 4'd0;
    logic [11:0] load_freq = 12'd0;
    logic [3:0]  load_dur = 4'd0;
    logic [11:0] freq;
    logic        play;
    logic        busy;
    logic [3:0]  step_idx;
    logic        done;

    note_sequencer #(.TICK_DIV(TD), .GAP_TICKS(GT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .load_we(load_we), .load_addr(load_addr), .load_freq(load_freq),
        .load_dur(load_dur), .freq(freq), .play(play), .busy(busy),
        .step_idx(step_idx), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [11:0] m_freq [16];
    logic [3:0]  m_dur  [16];

    typedef struct packed {
        logic [11:0] f;
        logic        p;
        logic        b;
        logic [3:0]  i;
        logic        d;
    } smp_t;

    smp_t exq[$];
    smp_t obs[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int a, input logic [11:0] f, input logic [3:0] d);
        load_we   = 1'b1;
        load_addr = a[3:0];
        load_freq = f;
        load_dur  = d;
        step();
        load_we = 1'b0;
        m_freq[a] = f;
        m_dur[a]  = d;
    endtask

    // Expected cycle-by-cycle outputs of a full playback, starting with the
    // first cycle after start is accepted.
    task automatic build_trace();
        smp_t s;
        exq.delete();
        for (int e = 0; e < 16; e++) begin
            if (m_dur[e] == 4'd0) break;
            for (int c = 0; c < int'(m_dur[e]) * TD; c++) begin
                s.f = m_freq[e]; s.p = (m_freq[e] != 12'd0); s.b = 1'b1; s.i = e[3:0]; s.d = 1'b0;
                exq.push_back(s);
            end
            for (int c = 0; c < GT * TD; c++) begin
                s.f = m_freq[e]; s.p = 1'b0; s.b = 1'b1; s.i = e[3:0]; s.d = 1'b0;
                exq.push_back(s);
            end
        end
        s = '0; s.d = 1'b1;
        exq.push_back(s);
        s = '0;
        exq.push_back(s);
    endtask

    task automatic sample_push();
        smp_t s;
        s.f = freq; s.p = play; s.b = busy; s.i = step_idx; s.d = done;
        obs.push_back(s);
    endtask

    task automatic start_pulse();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic capture(input int n);
        obs.delete();
        for (int k = 0; k < n; k++) begin
            if (k > 0) step();
            sample_push();
        end
    endtask

    function automatic bit smp_ne(smp_t o, smp_t e);
        return (o.f !== e.f) || (o.p !== e.p) || (o.b !== e.b) || (o.d !== e.d) ||
               (e.b && (o.i !== e.i));
    endfunction

    function automatic string smp_str(smp_t s);
        return $sformatf("f=%0d p=%0b b=%0b i=%0d d=%0b", s.f, s.p, s.b, s.i, s.d);
    endfunction

    task automatic random_table(input int len, input int max_dur);
        for (int e = 0; e < len; e++)
            load(e, ($urandom_range(0, 3) == 0) ? 12'd0 : 12'($urandom_range(1, 4095)),
                 4'($urandom_range(1, max_dur)));
        if (len < 16) load(len, 12'($urandom), 4'd0);
    endtask

    task automatic basic_table();
        load(0, 12'd100, 4'd2);
        load(1, 12'd200, 4'd1);
        load(2, 12'd1445, 4'd0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b1; stop = 1'b0;
        step(); step();
        checks++; if (freq !== 12'd0) begin errors++; $display("FAIL reset_freq got %0d want 0", freq); end
        checks++; if (play !== 1'b0) begin errors++; $display("FAIL reset_play got %b want 0", play); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (step_idx !== 4'd0) begin errors++; $display("FAIL reset_idx got %0d want 0", step_idx); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        start = 1'b0; rst_n = 1'b1;
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_release_busy got %b want 0", busy); end
    endtask

    task automatic test_basic();
        int hi100, hi200;
        basic_table();
        build_trace();
        start_pulse();
        capture(exq.size());
        for (int k = 0; k < exq.size(); k++) begin
            checks++;
            if (smp_ne(obs[k], exq[k])) begin
                errors++; $display("FAIL basic cyc %0d got %s want %s", k, smp_str(obs[k]), smp_str(exq[k]));
            end
        end
        hi100 = 0; hi200 = 0;
        foreach (obs[k]) begin
            if (obs[k].p === 1'b1 && obs[k].f === 12'd100) hi100++;
            if (obs[k].p === 1'b1 && obs[k].f === 12'd200) hi200++;
        end
        checks++; if (hi100 != 8) begin errors++; $display("FAIL basic_hi100 got %0d want 8", hi100); end
        checks++; if (hi200 != 4) begin errors++; $display("FAIL basic_hi200 got %0d want 4", hi200); end
        checks++; if (obs[20].d !== 1'b1) begin errors++; $display("FAIL basic_done_at20 got %b want 1", obs[20].d); end
    endtask

    task automatic test_empty_start();
        load(0, 12'd123, 4'd0);
        build_trace();
        start_pulse();
        capture(exq.size());
        for (int k = 0; k < exq.size(); k++) begin
            checks++;
            if (smp_ne(obs[k], exq[k])) begin
                errors++; $display("FAIL empty cyc %0d got %s want %s", k, smp_str(obs[k]), smp_str(exq[k]));
            end
        end
    endtask

    task automatic test_rest_entry();
        load(0, 12'd100, 4'd2);
        load(1, 12'd0, 4'd3);
        load(2, 12'd300, 4'd1);
        load(3, 12'd7, 4'd0);
        build_trace();
        start_pulse();
        capture(exq.size());
        for (int k = 0; k < exq.size(); k++) begin
            checks++;
            if (smp_ne(obs[k], exq[k])) begin
                errors++; $display("FAIL rest cyc %0d got %s want %s", k, smp_str(obs[k]), smp_str(exq[k]));
            end
        end
    endtask

    task automatic test_random_play();
        for (int r = 0; r < 6; r++) begin
            random_table($urandom_range(1, 15), 3);
            build_trace();
            start_pulse();
            capture(exq.size());
            for (int k = 0; k < exq.size(); k++) begin
                checks++;
                if (smp_ne(obs[k], exq[k])) begin
                    errors++; $display("FAIL random%0d cyc %0d got %s want %s", r, k, smp_str(obs[k]), smp_str(exq[k]));
                end
            end
            step();
        end
    endtask

    task automatic test_all16();
        for (int e = 0; e < 16; e++) load(e, 12'($urandom_range(1, 4095)), 4'd1);
        build_trace();
        start_pulse();
        capture(exq.size());
        for (int k = 0; k < exq.size(); k++) begin
            checks++;
            if (smp_ne(obs[k], exq[k])) begin
                errors++; $display("FAIL all16 cyc %0d got %s want %s", k, smp_str(obs[k]), smp_str(exq[k]));
            end
        end
    endtask

    task automatic test_stop();
        int kstop;
        for (int r = 0; r < 5; r++) begin
            if (r == 0) basic_table();
            else random_table($urandom_range(1, 6), 3);
            build_trace();
            kstop = (r == 0) ? 3 : int'($urandom_range(1, exq.size() - 2));
            start_pulse();
            capture(kstop);
            for (int k = 0; k < kstop; k++) begin
                checks++;
                if (smp_ne(obs[k], exq[k])) begin
                    errors++; $display("FAIL stop%0d pre cyc %0d got %s want %s", r, k, smp_str(obs[k]), smp_str(exq[k]));
                end
            end
            stop = 1'b1;
            step();
            stop = 1'b0;
            checks++;
            if (freq !== 12'd0 || play !== 1'b0 || busy !== 1'b0 || step_idx !== 4'd0 || done !== 1'b0) begin
                errors++;
                $display("FAIL stop%0d after got f=%0d p=%b b=%b i=%0d d=%b want all 0", r, freq, play, busy, step_idx, done);
            end
            for (int k = 0; k < 5; k++) begin
                step();
                checks++;
                if (done !== 1'b0 || busy !== 1'b0 || play !== 1'b0) begin
                    errors++; $display("FAIL stop%0d idle cyc %0d got d=%b b=%b p=%b want 0", r, k, done, busy, play);
                end
            end
        end
    endtask

    task automatic test_start_stop_same();
        basic_table();
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (busy !== 1'b0 || play !== 1'b0 || done !== 1'b0 || freq !== 12'd0) begin
                errors++; $display("FAIL startstop cyc %0d got b=%b p=%b d=%b f=%0d want idle", k, busy, play, done, freq);
            end
            step();
        end
    endtask

    task automatic test_reset_in_gap();
        basic_table();
        build_trace();
        start_pulse();
        capture(10);
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (smp_ne(obs[k], exq[k])) begin
                errors++; $display("FAIL rstgap pre cyc %0d got %s want %s", k, smp_str(obs[k]), smp_str(exq[k]));
            end
        end
        rst_n = 1'b0; start = 1'b1;
        load_we = 1'b1; load_addr = 4'd0; load_freq = 12'd999; load_dur = 4'd5;
        for (int k = 0; k < 2; k++) begin
            step();
            checks++;
            if (freq !== 12'd0 || play !== 1'b0 || busy !== 1'b0 || step_idx !== 4'd0 || done !== 1'b0) begin
                errors++;
                $display("FAIL rstgap cyc %0d got f=%0d p=%b b=%b i=%0d d=%b want all 0", k, freq, play, busy, step_idx, done);
            end
        end
        rst_n = 1'b1; start = 1'b0; load_we = 1'b0;
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstgap_release_busy got %b want 0", busy); end
        start_pulse();
        capture(exq.size());
        for (int k = 0; k < exq.size(); k++) begin
            checks++;
            if (smp_ne(obs[k], exq[k])) begin
                errors++; $display("FAIL rstgap replay cyc %0d got %s want %s", k, smp_str(obs[k]), smp_str(exq[k]));
            end
        end
    endtask

    task automatic test_load_while_busy();
        int n;
        random_table(4, 3);
        build_trace();
        n = exq.size();
        start_pulse();
        obs.delete();
        sample_push();
        for (int k = 1; k < n; k++) begin
            if (k <= n - 2 && (k % 3) == 1) begin
                load_we   = 1'b1;
                load_addr = 4'($urandom_range(0, 15));
                load_freq = 12'($urandom);
                load_dur  = 4'($urandom_range(0, 15));
            end
            if (k == 5) start = 1'b1;
            step();
            load_we = 1'b0; start = 1'b0;
            sample_push();
        end
        for (int k = 0; k < n; k++) begin
            checks++;
            if (smp_ne(obs[k], exq[k])) begin
                errors++; $display("FAIL busyload cyc %0d got %s want %s", k, smp_str(obs[k]), smp_str(exq[k]));
            end
        end
        step();
        start_pulse();
        capture(n);
        for (int k = 0; k < n; k++) begin
            checks++;
            if (smp_ne(obs[k], exq[k])) begin
                errors++; $display("FAIL busyload replay cyc %0d got %s want %s", k, smp_str(obs[k]), smp_str(exq[k]));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_empty_start();
        test_rest_entry();
        test_random_play();
        test_all16();
        test_stop();
        test_start_stop_same();
        test_reset_in_gap();
        test_load_while_busy();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/note_sequencer.md
NOTE_SEQUENCER -- requirements
Module: note_sequencer

Interface
REQ-001 Parameter TICK_DIV, default 12500000: clk cycles per sequencer tick; legal range >= 2.
REQ-002 Parameter GAP_TICKS, default 1: silent ticks inserted after each note; legal range >= 1.
REQ-003 clk  input  1  system clock; the block SHALL use this single clock.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  single-cycle pulse that begins playback at entry 0.
REQ-006 stop  input  1  single-cycle pulse that aborts playback.
REQ-007 load_we  input  1  note-table write strobe.
REQ-008 load_addr  input  4  note-table write index 0..15.
REQ-009 load_freq  input  12  note frequency code; 0 means rest.
REQ-010 load_dur  input  4  note length in ticks; 0 means end-of-sequence marker.
REQ-011 freq  output  12  frequency code to the oscillators.
REQ-012 play  output  1  gate to the signal adder.
REQ-013 busy  output  1  high while in the NOTE or GAP state.
REQ-014 step_idx  output  4  index of the current table entry.
REQ-015 done  output  1  one-cycle pulse when playback completes.

Function
REQ-016 The block SHALL hold a 16-entry table {freq[11:0], dur[3:0]} in registers, written on load_we only while busy=0; writes while busy=1 SHALL be ignored.
REQ-017 The FSM SHALL have exactly three states: IDLE, NOTE, GAP.
REQ-018 The prescaler SHALL count 0..TICK_DIV-1 and assert an internal tick when the count is TICK_DIV-1; it SHALL clear on every start acceptance and every NOTE/GAP entry.
REQ-019 Start SHALL be accepted in IDLE only, and only if entry 0 has dur!=0. On the next cycle: state=NOTE, step_idx=0, freq=table[0].freq, play=(table[0].freq!=0). Latency is 1 cycle.
REQ-020 If start arrives in IDLE with entry 0 dur=0, the block SHALL remain in IDLE and pulse done for one cycle.
REQ-021 Start while busy=1 SHALL be ignored.
REQ-022 NOTE: the block SHALL count ticks; on the dur-th tick it SHALL enter GAP with play=0 and freq held.
REQ-023 GAP: on the GAP_TICKS-th tick the block SHALL advance idx+1.
REQ-024 Advance: if idx was 15 (wrap to 0) or the next entry has dur=0, the sequence end is reached (REQ-035/036); otherwise the block SHALL enter NOTE with the next entry's freq/play on the following cycle.
REQ-025 Table entries SHALL be sampled when NOTE is entered; later table contents SHALL NOT affect a note in progress.
REQ-026 Stop in NOTE or GAP SHALL cause IDLE on the next cycle with play=0, freq=0, step_idx=0, and no done pulse.
REQ-027 If start and stop are asserted in the same cycle, stop SHALL take priority.
REQ-028 busy SHALL be 1 exactly when state is NOTE or GAP.
REQ-029 All outputs SHALL be registered.

Reset
REQ-030 rst_n=0 sampled on a clk edge SHALL force: state=IDLE, freq=0, play=0, busy=0, step_idx=0, done=0, prescaler=0, tick counter=0.
REQ-031 Reset SHALL take effect from any state, including mid-note; play SHALL be 0 in the cycle after reset is sampled.
REQ-032 Table contents are undefined after power-up and SHALL NOT be cleared by reset.
REQ-033 While rst_n=0, start, stop and load_we SHALL be ignored.

Configuration
REQ-034 The feature macro SHALL be SEQ_LOOP_EN.
REQ-035 With SEQ_LOOP_EN undefined, reaching the sequence end SHALL go to IDLE with play=0 and freq=0, and pulse done for one cycle.
REQ-036 With SEQ_LOOP_EN defined, reaching the sequence end SHALL re-enter NOTE at entry 0 with no done pulse; only stop or reset SHALL end playback.

Verification
REQ-037 Setup TICK_DIV=4, GAP_TICKS=1; table {0:(100,2), 1:(200,1), 2:(x,0)}; start -> play high 8 cycles at freq=100, low 4, high 4 at freq=200, low 4, then done pulse; play low afterwards.
REQ-038 Stop asserted 3 cycles into note 0 -> next cycle play=0, freq=0, busy=0, no done pulse.
REQ-039 Start and stop asserted together in IDLE -> stays IDLE, busy=0.
REQ-040 Entry 1 freq=0 -> freq=0 and play=0 for entry 1's duration; step_idx=1 during that time.
REQ-041 All 16 entries dur=1 -> step_idx counts 0..15, then done (SEQ_LOOP_EN undefined) or step_idx returns to 0 with busy held high (SEQ_LOOP_EN defined).
REQ-042 rst_n low during GAP -> all outputs at reset values next cycle; load_we during busy -> table unchanged, checked by a subsequent replay.
